// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation codes, FSM states and default width for the multiply/divide unit
package mdu_pkg;
   localparam int XLEN_DEFAULT = 32;
   typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mdu_op_e;
   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} mdu_state_e;
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: (XLEN+1)-bit adder/subtractor shared by the multiply add and divide trial-subtract
module mdu_addsub import mdu_pkg::*; #(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN:0] a,
   input  logic [XLEN:0] b,
   input  logic          sub,
   output logic [XLEN:0] sum,
   output logic          borrow
);
   assign sum    = sub ? a - b : a + b;
   assign borrow = sub & sum[XLEN];
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 RV32M multiply/divide unit with start/valid handshake
module mul_div_unit import mdu_pkg::*; #(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   mdu_state_e        state;
   mdu_op_e           op_q;
   logic [CW-1:0]     cnt;
   logic              neg_q;
   logic [XLEN-1:0]   m_q;
   logic [2*XLEN-1:0] p_q, p_next, p_fix;
   logic [XLEN-1:0]   rs1_mag, rs2_mag, spec_res, rem_fix, res_fix;
   logic              s1, s2, neg_d, div_zero, ovf, special;
   logic [XLEN:0]     as_a, as_b, as_sum;
   logic              borrow;

   mdu_addsub #(.XLEN(XLEN)) u_addsub (
      .a(as_a), .b(as_b), .sub(op_q[2]), .sum(as_sum), .borrow(borrow)
   );

   // operand conditioning, special-case detection, one iteration step and final sign fix-up
   always_comb begin
      s1       = rs1[XLEN-1] & (op == MULH || op == MULHSU || op == DIV || op == REM);
      s2       = rs2[XLEN-1] & (op == MULH || op == DIV || op == REM);
      neg_d    = (op == REM) ? s1 : s1 ^ s2;
      rs1_mag  = s1 ? ~rs1 + XLEN'(1) : rs1;
      rs2_mag  = s2 ? ~rs2 + XLEN'(1) : rs2;
      div_zero = op[2] & (rs2 == '0);
      ovf      = op[2] & ~op[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
      special  = div_zero | ovf;
      spec_res = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
      as_a     = op_q[2] ? p_q[2*XLEN-1:XLEN-1] : {1'b0, p_q[2*XLEN-1:XLEN]};
      as_b     = {1'b0, m_q & {XLEN{op_q[2] | p_q[0]}}};
      p_next   = ~op_q[2] ? {as_sum, p_q[XLEN-1:1]} :
                 borrow ? {p_q[2*XLEN-2:0], 1'b0} : {as_sum[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
      p_fix    = neg_q ? ~p_q + (2*XLEN)'(1) : p_q;
      rem_fix  = neg_q ? ~p_q[2*XLEN-1:XLEN] + XLEN'(1) : p_q[2*XLEN-1:XLEN];
      res_fix  = (op_q[2] & op_q[1]) ? rem_fix :
                 (op_q[2] | op_q[1:0] == 2'b00) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
   end

   // control FSM with registered busy/valid/result; flush aborts without touching result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         valid  <= 1'b0;
         result <= '0;
         cnt    <= '0;
         op_q   <= MUL;
         neg_q  <= 1'b0;
         m_q    <= '0;
         p_q    <= '0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  op_q  <= mdu_op_e'(op);
                  neg_q <= neg_d;
                  m_q   <= op[2] ? rs2_mag : rs1_mag;
                  p_q   <= {{XLEN{1'b0}}, op[2] ? rs1_mag : rs2_mag};
                  if (special) begin
                     result <= spec_res;
                     valid  <= 1'b1;
                     state  <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= ITER;
                  end
               end
            end
            ITER: begin
               p_q <= p_next;
               cnt <= (cnt == CW'(XLEN-1)) ? '0 : cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) state <= FIX;
            end
            FIX: begin
               result <= res_fix;
               valid  <= 1'b1;
               busy   <= 1'b0;
               state  <= DONE;
            end
            DONE: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for the iterative multiply/divide unit
module tb_mul_div_unit;
   import mdu_pkg::*;
   logic        clk = 1'b0;
   logic        rst, start, flush, busy, valid;
   logic [2:0]  op;
   logic [31:0] rs1, rs2, result;
   int checks = 0, errors = 0;

   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .flush(flush), .busy(busy), .valid(valid), .result(result)
   );

   always #5 clk = ~clk;

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b; lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (valid) begin lat = n; break; end
      end
      res = result;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL reset: busy=%b valid=%b result=%h required 0 0 0", busy, valid, result); end
      rst = 1'b0;
   endtask

   task automatic test_mul();
      int lat; logic [31:0] res;
      do_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
      checks++; if (res !== 32'hFFFFFFFE || lat != 34) begin errors++; $display("FAIL mulhu: result=%h lat=%0d required fffffffe 34", res, lat); end
      do_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
      checks++; if (res !== 32'h00000001 || lat != 34) begin errors++; $display("FAIL mul: result=%h lat=%0d required 00000001 34", res, lat); end
      do_op(MULH, 32'h80000000, 32'h80000000, lat, res);
      checks++; if (res !== 32'h40000000) begin errors++; $display("FAIL mulh: result=%h required 40000000", res); end
      do_op(MULHSU, 32'hFFFFFFFF, 32'h00000002, lat, res);
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: result=%h required ffffffff", res); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_valid: busy=%b required 0", busy); end
   endtask

   task automatic test_div();
      int lat; logic [31:0] res;
      do_op(DIV, 32'hFFFFFFF9, 32'd2, lat, res);
      checks++; if (res !== 32'hFFFFFFFD || lat != 34) begin errors++; $display("FAIL div: result=%h lat=%0d required fffffffd 34", res, lat); end
      do_op(REM, 32'hFFFFFFF9, 32'd2, lat, res);
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem: result=%h required ffffffff", res); end
      do_op(DIVU, 32'd100, 32'd7, lat, res);
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu: result=%h required 0000000e", res); end
      do_op(REMU, 32'd100, 32'd7, lat, res);
      checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu: result=%h required 00000002", res); end
   endtask

   task automatic test_special();
      int lat; logic [31:0] res;
      do_op(DIV, 32'd5, 32'd0, lat, res);
      checks++; if (res !== 32'hFFFFFFFF || lat != 1) begin errors++; $display("FAIL div_by_zero: result=%h lat=%0d required ffffffff 1", res, lat); end
      do_op(REM, 32'd5, 32'd0, lat, res);
      checks++; if (res !== 32'd5 || lat != 1) begin errors++; $display("FAIL rem_by_zero: result=%h lat=%0d required 00000005 1", res, lat); end
      do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, res);
      checks++; if (res !== 32'h80000000 || lat != 1) begin errors++; $display("FAIL div_ovf: result=%h lat=%0d required 80000000 1", res, lat); end
      do_op(REM, 32'h80000000, 32'hFFFFFFFF, lat, res);
      checks++; if (res !== 32'h0 || lat != 1) begin errors++; $display("FAIL rem_ovf: result=%h lat=%0d required 00000000 1", res, lat); end
   endtask

   task automatic test_flush();
      int lat; logic [31:0] res;
      do_op(MUL, 32'd1, 32'd1, lat, res);
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd7;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_flush: busy=%b required 0", busy); end
      start = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd1) begin errors++; $display("FAIL flush: busy=%b valid=%b result=%h required 0 0 00000001", busy, valid, result); end
      do_op(DIVU, 32'd100, 32'd7, lat, res);
      checks++; if (res !== 32'd14 || lat != 34) begin errors++; $display("FAIL after_flush: result=%h lat=%0d required 0000000e 34", res, lat); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; op = MULHU; rs1 = 32'd3; rs2 = 32'd5;
      repeat (5) begin @(negedge clk); start = 1'b0; end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL async_reset: busy=%b valid=%b result=%h required 0 0 00000000", busy, valid, result); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_busy_ignore();
      int lat = 0;
      @(negedge clk);
      start = 1'b1; op = DIV; rs1 = 32'hFFFFFFF9; rs2 = 32'd2;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = (n == 5 || n == 20);
         op = MUL; rs1 = 32'd3; rs2 = 32'd3;
         if (valid) begin lat = n; break; end
      end
      start = 1'b0;
      checks++; if (result !== 32'hFFFFFFFD || lat != 34) begin errors++; $display("FAIL start_while_busy: result=%h lat=%0d required fffffffd 34", result, lat); end
   endtask

   task automatic test_back_to_back();
      int lat = 0; logic [31:0] res;
      do_op(REMU, 32'd100, 32'd7, lat, res);
      start = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd7; lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b required 0", busy); end
         end else start = 1'b0;
         if (valid) begin lat = n; break; end
      end
      start = 1'b0;
      checks++; if (result !== 32'd14 || lat != 35) begin errors++; $display("FAIL back_to_back: result=%h lat=%0d required 0000000e 35", result, lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
